// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_sequencer_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALTED   = 2'd2,
      MEM_ERR  = 2'd3
   } seq_state_e;

   localparam int MEM_TIMEOUT_DEF = 16;
   localparam int CNT_W_DEF       = 32;
endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   // Holds at all-ones so long runs report "at least" rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + WIDTH'(1);
   end
endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush controller: per-stage enables/flushes, data-memory
// handshake with timeout, and cycle/stall performance counters.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bubble,
   input  logic             branch_taken,
   input  logic             mem_op_xm,
   input  logic             mem_ack,
   input  logic             halt,
   output logic             pc_en,
   output logic             fd_en,
   output logic             dx_en,
   output logic             xm_en,
   output logic             mw_en,
   output logic             fd_flush,
   output logic             dx_flush,
   output logic             xm_flush,
   output logic             mem_req,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int              TO_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   seq_state_e      state;
   logic            mem_done;
   logic [TO_W-1:0] to_cnt;
   logic            active;
   logic            stall_inc;

   // Same-cycle enable/flush decode; only RUN ever lets anything advance.
   always_comb begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_en    = 1'b0;
      xm_en    = 1'b0;
      mw_en    = 1'b0;
      fd_flush = 1'b0;
      dx_flush = 1'b0;
      xm_flush = 1'b0;
      if (!reset && (state == RUN)) begin
         if (halt || (mem_op_xm && !mem_done)) begin
            pc_en = 1'b0;
         end else if (bubble) begin
            // Branch stays parked in DX and is resolved again next cycle.
            xm_en    = 1'b1;
            mw_en    = 1'b1;
            xm_flush = 1'b1;
         end else begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            dx_en    = 1'b1;
            xm_en    = 1'b1;
            mw_en    = 1'b1;
            fd_flush = branch_taken;
            dx_flush = branch_taken;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         mem_done <= 1'b0;
         to_cnt   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (halt) begin
                  state <= HALTED;
               end else if (mem_op_xm && !mem_done) begin
                  state  <= MEM_WAIT;
                  to_cnt <= '0;
               end
               // Completed access leaves XM, so the next one must request again.
               if (xm_en)
                  mem_done <= 1'b0;
            end
            MEM_WAIT: begin
               to_cnt <= to_cnt + TO_W'(1);
               if (mem_ack) begin
                  state    <= RUN;
                  mem_done <= 1'b1;
               end else if (to_cnt == TO_LAST) begin
                  state <= MEM_ERR;
               end
            end
            HALTED:  state <= HALTED;
            MEM_ERR: state <= MEM_ERR;
            default: state <= RUN;
         endcase
      end
   end

   assign mem_req = (state == MEM_WAIT);
   assign halted  = (state == HALTED);
   assign mem_err = (state == MEM_ERR);

   assign active    = (state == RUN) || (state == MEM_WAIT);
   assign stall_inc = active && !pc_en;

   sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (active),
      .count (cycle_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_cnt)
   );
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the sequencing rules.
module tb_pipeline_sequencer;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic bubble = 1'b0, branch_taken = 1'b0, mem_op_xm = 1'b0;
   logic mem_ack = 1'b0, halt = 1'b0;

   logic pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush;
   logic mem_req, halted, mem_err;
   logic [31:0] cycle_cnt, stall_cnt;

   logic pc_en2, fd_en2, dx_en2, xm_en2, mw_en2, fd_flush2, dx_flush2, xm_flush2;
   logic mem_req2, halted2, mem_err2;
   logic [3:0] cycle_cnt2, stall_cnt2;

   logic [10:0] ctl1, ctl2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipeline_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .bubble(bubble), .branch_taken(branch_taken),
      .mem_op_xm(mem_op_xm), .mem_ack(mem_ack), .halt(halt),
      .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
      .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
      .mem_req(mem_req), .halted(halted), .mem_err(mem_err),
      .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
   );

   // Narrow counters so saturation is reachable in a short run.
   pipeline_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .bubble(bubble), .branch_taken(branch_taken),
      .mem_op_xm(mem_op_xm), .mem_ack(mem_ack), .halt(halt),
      .pc_en(pc_en2), .fd_en(fd_en2), .dx_en(dx_en2), .xm_en(xm_en2), .mw_en(mw_en2),
      .fd_flush(fd_flush2), .dx_flush(dx_flush2), .xm_flush(xm_flush2),
      .mem_req(mem_req2), .halted(halted2), .mem_err(mem_err2),
      .cycle_cnt(cycle_cnt2), .stall_cnt(stall_cnt2)
   );

   assign ctl1 = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
                  mem_req, halted, mem_err};
   assign ctl2 = {pc_en2, fd_en2, dx_en2, xm_en2, mw_en2, fd_flush2, dx_flush2, xm_flush2,
                  mem_req2, halted2, mem_err2};

   // Model: waiting = number of request cycles so far (-1 when no access pending).
   int     m_wait  = -1;
   bit     m_done  = 1'b0;
   bit     m_halt  = 1'b0;
   bit     m_err   = 1'b0;
   longint m_cyc   = 0;
   longint m_stall = 0;

   function automatic longint sat(longint v, longint mx);
      return (v > mx) ? mx : v;
   endfunction

   always @(negedge clk) begin
      bit run;
      bit e_pc, e_fd, e_dx, e_xm, e_mw, e_fdf, e_dxf, e_xmf;
      logic [10:0] e;
      longint ec, es;
      run = !reset && !m_halt && !m_err && (m_wait < 0);
      {e_pc, e_fd, e_dx, e_xm, e_mw, e_fdf, e_dxf, e_xmf} = 8'b0;
      if (run && !halt && !(mem_op_xm && !m_done)) begin
         if (bubble) begin
            e_xm = 1'b1; e_mw = 1'b1; e_xmf = 1'b1;
         end else begin
            {e_pc, e_fd, e_dx, e_xm, e_mw} = 5'b11111;
            e_fdf = branch_taken;
            e_dxf = branch_taken;
         end
      end
      e = {e_pc, e_fd, e_dx, e_xm, e_mw, e_fdf, e_dxf, e_xmf,
           !reset && (m_wait >= 0) && !m_halt && !m_err,
           !reset && m_halt, !reset && m_err};
      ec = reset ? 0 : m_cyc;
      es = reset ? 0 : m_stall;

      n_tests++;
      if (ctl1 !== e) begin
         n_fail++;
         $display("FAIL ctl @%0t: got %b want %b", $time, ctl1, e);
      end
      n_tests++;
      if (ctl2 !== e) begin
         n_fail++;
         $display("FAIL ctl_small @%0t: got %b want %b", $time, ctl2, e);
      end
      n_tests++;
      if ({cycle_cnt, stall_cnt} !== {32'(sat(ec, 64'hFFFF_FFFF)), 32'(sat(es, 64'hFFFF_FFFF))}) begin
         n_fail++;
         $display("FAIL counters @%0t: got %0d/%0d want %0d/%0d", $time, cycle_cnt, stall_cnt, ec, es);
      end
      n_tests++;
      if ({cycle_cnt2, stall_cnt2} !== {4'(sat(ec, 15)), 4'(sat(es, 15))}) begin
         n_fail++;
         $display("FAIL counters_small @%0t: got %0d/%0d want %0d/%0d", $time, cycle_cnt2, stall_cnt2,
                  sat(ec, 15), sat(es, 15));
      end

      // Advance the model by this cycle.
      if (reset) begin
         m_wait = -1; m_done = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_cyc = 0; m_stall = 0;
      end else if (m_halt || m_err) begin
         m_cyc = m_cyc;
      end else if (m_wait >= 0) begin
         m_cyc++;
         m_stall++;
         if (mem_ack) begin
            m_wait = -1;
            m_done = 1'b1;
         end else begin
            m_wait++;
            if (m_wait == TMO) begin
               m_err  = 1'b1;
               m_wait = -1;
            end
         end
      end else begin
         m_cyc++;
         if (!e_pc) m_stall++;
         if (halt) m_halt = 1'b1;
         else if (mem_op_xm && !m_done) m_wait = 0;
         else if (e_xm) m_done = 1'b0;
      end
   end

   task automatic drive(input bit r, input bit b, input bit br, input bit mo,
                        input bit ack, input bit h);
      @(posedge clk);
      #1;
      reset = r; bubble = b; branch_taken = br; mem_op_xm = mo; mem_ack = ack; halt = h;
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   localparam logic [10:0] ALL_RUN = 11'b11111_000_000;
   localparam logic [10:0] BUBBLE  = 11'b00011_001_000;
   localparam logic [10:0] FROZEN  = 11'b00000_000_000;
   localparam logic [10:0] REQ     = 11'b00000_000_100;
   localparam logic [10:0] BRANCH  = 11'b11111_110_000;
   localparam logic [10:0] HALT_S  = 11'b00000_000_010;
   localparam logic [10:0] ERR_S   = 11'b00000_000_001;

   initial begin
      @(negedge clk);
      #1;
      chk("reset_ctl", 64'(ctl1), 64'(FROZEN));
      chk("reset_cnt", 64'(cycle_cnt), 64'd0);

      repeat (5) drive(0, 0, 0, 0, 0, 0);
      chk("idle_ctl", 64'(ctl1), 64'(ALL_RUN));
      drive(0, 1, 0, 0, 0, 0);
      chk("idle_cycles", 64'(cycle_cnt), 64'd5);
      chk("idle_stalls", 64'(stall_cnt), 64'd0);
      chk("bubble_ctl", 64'(ctl1), 64'(BUBBLE));
      drive(0, 0, 0, 0, 0, 0);
      chk("bubble_stall", 64'(stall_cnt), 64'd1);
      chk("after_bubble", 64'(ctl1), 64'(ALL_RUN));

      drive(0, 0, 0, 1, 0, 0);
      chk("mem_detect", 64'(ctl1), 64'(FROZEN));
      drive(0, 0, 0, 1, 0, 0);
      chk("mem_req1", 64'(ctl1), 64'(REQ));
      drive(0, 0, 0, 1, 0, 0);
      chk("mem_req2", 64'(ctl1), 64'(REQ));
      drive(0, 0, 0, 1, 1, 0);
      chk("mem_req3", 64'(ctl1), 64'(REQ));
      drive(0, 0, 0, 1, 0, 0);
      chk("mem_advance", 64'(ctl1), 64'(ALL_RUN));
      drive(0, 0, 0, 0, 0, 0);
      chk("mem_stalls", 64'(stall_cnt), 64'd5);
      chk("mem_cycles", 64'(cycle_cnt), 64'd12);

      drive(0, 1, 1, 0, 0, 0);
      chk("bub_br_ctl", 64'(ctl1), 64'(BUBBLE));
      drive(0, 0, 1, 0, 0, 0);
      chk("br_ctl", 64'(ctl1), 64'(BRANCH));

      drive(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < TMO; i++) drive(0, 0, 0, 1, 0, 0);
      chk("last_req", 64'(ctl1), 64'(REQ));
      drive(0, 0, 0, 1, 0, 0);
      chk("err_ctl", 64'(ctl1), 64'(ERR_S));
      chk("err_cycles", 64'(cycle_cnt), 64'd32);
      chk("err_stalls", 64'(stall_cnt), 64'd23);
      chk("err_small_sat", 64'(cycle_cnt2), 64'd15);
      drive(0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 0);
      chk("late_ack_ctl", 64'(ctl1), 64'(ERR_S));
      chk("late_ack_cnt", 64'(cycle_cnt), 64'd32);

      drive(1, 0, 0, 0, 0, 0);
      chk("rst_ctl", 64'(ctl1), 64'(FROZEN));
      drive(0, 0, 0, 0, 0, 0);
      chk("rst_run", 64'(ctl1), 64'(ALL_RUN));

      drive(0, 1, 0, 0, 0, 1);
      chk("halt_ctl", 64'(ctl1), 64'(FROZEN));
      drive(0, 0, 0, 0, 0, 0);
      chk("halted_ctl", 64'(ctl1), 64'(HALT_S));
      drive(0, 0, 1, 1, 1, 0);
      chk("halted_hold", 64'(ctl1), 64'(HALT_S));

      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      chk("wait_req", 64'(ctl1), 64'(REQ));
      drive(1, 0, 0, 1, 0, 0);
      chk("async_rst_req", 64'(mem_req), 64'd0);
      drive(0, 0, 0, 0, 1, 0);
      chk("ack_after_rst", 64'(ctl1), 64'(ALL_RUN));
      drive(0, 0, 0, 1, 0, 0);
      chk("no_stale_done", 64'(ctl1), 64'(FROZEN));

      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 3,
               $urandom_range(0, 4) == 0, $urandom_range(0, 79) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush controller for the 5-stage pipeline: converts the hazard unit's `bubble`, the taken-branch signal, data-memory handshakes and the finish instruction into per-stage register enables and flushes. Owns the data-memory req/ack handshake, freezes the pipe while a load/store is outstanding and detects memory timeouts. It also keeps cycle and stall counters for performance reporting. It sits beside `hazard_detection` in the core top level and drives the enable/flush pins of the FD, DX, XM and MW pipeline registers and the PC.

## Interface
- `MEM_TIMEOUT`, 16: cycles `mem_req` may stay high without `mem_ack` before the error state; must be 2 or more.
- `CNT_W`, 32: width of the performance counters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `bubble` in 1: load-use stall request from `hazard_detection`.
- `branch_taken` in 1: the instruction in X resolved as a taken branch or jump.
- `mem_op_xm` in 1: the XM-stage instruction is a load or store (`is_load_op_c_xm | is_store_op_c_xm`).
- `mem_ack` in 1: data memory completion, one-cycle pulse.
- `halt` in 1: the finish instruction is in MW.
- `pc_en`, `fd_en`, `dx_en`, `xm_en`, `mw_en` out 1 each: register load enables.
- `fd_flush`, `dx_flush`, `xm_flush` out 1 each: the register loads a NOP instead of its input. Takes effect only when the matching `_en` is 1.
- `mem_req` out 1: data-memory request, held until acknowledged.
- `halted` out 1: core stopped by the finish instruction.
- `mem_err` out 1: sticky timeout error.
- `cycle_cnt` out CNT_W: saturating count of cycles spent in RUN or MEM_WAIT.
- `stall_cnt` out CNT_W: saturating count of cycles with `pc_en`=0 in RUN or MEM_WAIT.

## Operation
- States: `RUN`, `MEM_WAIT`, `HALTED`, `MEM_ERR`.
- Internal registers:
  - `mem_done`: the XM instruction's access has completed.
  - `to_cnt`: timeout counter, width $clog2(MEM_TIMEOUT+1).
- RUN priority, highest first:
  1. `halt`: next state HALTED; all enables 0 this cycle.
  2. `mem_op_xm && !mem_done`: next state MEM_WAIT; all enables 0; `to_cnt` <= 0.
  3. `bubble`: `pc_en`=`fd_en`=`dx_en`=0, `xm_en`=`mw_en`=1, `xm_flush`=1. `branch_taken` is ignored this cycle; the branch is held in DX and reasserts.
  4. `branch_taken`: all enables 1, `fd_flush`=`dx_flush`=1 (kills the two wrong-path instructions).
  5. Otherwise: all enables 1, no flushes.
- `mem_done` is set on the `mem_ack` cycle. It is cleared on any RUN cycle with `xm_en`=1, so the completed load/store advances once and does not re-request.
- MEM_WAIT:
  - All enables 0, `mem_req`=1, `to_cnt` increments each cycle.
  - `mem_ack`: next state RUN, `mem_done` <= 1.
  - Else if `to_cnt == MEM_TIMEOUT-1`: next state MEM_ERR.
  - `halt`, `bubble` and `branch_taken` are ignored.
- HALTED and MEM_ERR: all enables 0, `mem_req` 0, counters frozen. They are left only by `reset`.
- `mem_ack` outside MEM_WAIT is ignored.
- Counters saturate at all-ones and do not wrap.

## Timing
- State, `mem_done`, `to_cnt` and the counters are registered.
- Enables and flushes are combinational from the current state and inputs (same-cycle response to `bubble`, `branch_taken`, `halt` and `mem_op_xm`).
- `mem_req` = (state == MEM_WAIT): it rises the cycle after `mem_op_xm` is seen in RUN and drops in the cycle after `mem_ack`.
- Minimum load/store cost: 1 detect cycle, 1 request cycle with ack, then advance. That is 2 stall cycles in total.
- Reset values: state RUN, `mem_done`=0, `to_cnt`=0, counters 0, `mem_req`/`halted`/`mem_err` = 0.
- While `reset`=1, all enables and flushes are forced to 0.
- `halted` = (state == HALTED) and `mem_err` = (state == MEM_ERR), both decoded from the state register.
- Reset asserted mid-MEM_WAIT drops `mem_req` immediately (asynchronously). A late `mem_ack` after reset is ignored.

## Structure
- `definitions.sv` gains:
  - `typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, MEM_ERR} seq_state_e`
  - `localparam` default for `MEM_TIMEOUT`
- One sub-module, `sat_counter` (parameter width, input `inc`, async reset), instantiated twice for `cycle_cnt` and `stall_cnt`.

## Test plan
- Reset, then 5 idle cycles: all enables 1, no flushes, `cycle_cnt`=5, `stall_cnt`=0.
- `bubble` for 1 cycle: `pc_en`/`fd_en`/`dx_en`=0, `xm_flush`=1 that cycle, `stall_cnt`=1. Normal operation resumes the next cycle.
- `mem_op_xm`=1 with `mem_ack` 3 cycles after `mem_req` rises:
  - `mem_req` high for exactly 3 cycles and all enables 0 for 4 cycles.
  - Then one cycle with all enables 1 and no second `mem_req`.
  - `stall_cnt`=4.
- `bubble` and `branch_taken` together, then `branch_taken` alone: first cycle has no `fd_flush`; second cycle has `fd_flush`=`dx_flush`=1.
- `mem_op_xm` with no ack and `MEM_TIMEOUT`=16:
  - MEM_ERR is entered after 16 request cycles; `mem_err`=1 and `mem_req`=0.
  - Counters freeze; a late `mem_ack` has no effect.
  - `reset` returns to RUN.
- `halt` during `bubble`: `halted`=1 the next cycle and all enables 0. A `reset` pulse mid-MEM_WAIT clears `mem_req` in the same cycle.
